// File: rtl/gf32_pkg.sv
// rtl/gf32_pkg.sv - GF(2^5) field constants and id-width helper
package gf32_pkg;

    localparam int         GF_W     = 5;
    // Low terms of x^5 + x^2 + 1; the x^5 term is implicit in the reduction.
    localparam logic [4:0] GF_POLY  = 5'b00101;
    localparam logic [4:0] GF_ONE   = 5'b00001;
    localparam logic [4:0] GF_ALPHA = 5'b00010;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mac_arbiter_if.sv
// rtl/gf_mac_arbiter_if.sv - request/grant and result bus of the shared GF MAC
interface gf_mac_arbiter_if
    import gf32_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int SYM_W = GF_W
);
    logic [NREQ-1:0]       req;
    logic [NREQ*SYM_W-1:0] op_a;
    logic [NREQ*SYM_W-1:0] op_b;
    logic [NREQ*SYM_W-1:0] op_c;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic [IDW-1:0]        res_id;
    logic [SYM_W-1:0]      res_data;
    logic                  res_ready;

    modport slave (
        input  req, op_a, op_b, op_c, res_ready,
        output gnt, res_valid, res_id, res_data
    );

    modport master (
        output req, op_a, op_b, op_c, res_ready,
        input  gnt, res_valid, res_id, res_data
    );
endinterface

// File: rtl/gf_mac_arbiter_rr_arbiter.sv
// rtl/gf_mac_arbiter_rr_arbiter.sv - round-robin arbiter owning the rotate pointer
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_any_o
);
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  rr_ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  idx;
    logic [IDW-1:0]  jj;
    logic            found;
    int              j;

    // Scan from rr_ptr upward, wrapping, and take the first live request.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            jj = IDW'(j);
            if (!found && req_i[jj]) begin
                found   = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
        if (!accept_i || rst_i) begin
            found = 1'b0;
            gnt   = '0;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt_o     = gnt;
    assign gnt_idx_o = idx;
    assign gnt_any_o = found;
endmodule

// File: rtl/gfadder.sv
// rtl/gfadder.sv - GF(2^5) addition (carry-free XOR)
module gfadder
    import gf32_pkg::*;
(
    input  logic [GF_W-1:0] x_i,
    input  logic [GF_W-1:0] y_i,
    output logic [GF_W-1:0] s_o
);
    assign s_o = x_i ^ y_i;
endmodule

// File: rtl/lcpmult.sv
// rtl/lcpmult.sv - combinational GF(2^5) multiplier, polynomial basis
module lcpmult
    import gf32_pkg::*;
(
    input  logic [GF_W-1:0] a_i,
    input  logic [GF_W-1:0] b_i,
    output logic [GF_W-1:0] p_o
);
    logic [GF_W-1:0] acc;

    // MSB-first Horner: shift, fold x^5 back via the polynomial, add a.
    always_comb begin
        acc = '0;
        for (int i = GF_W - 1; i >= 0; i--) begin
            acc = {acc[GF_W-2:0], 1'b0} ^ (acc[GF_W-1] ? GF_POLY : '0);
            if (b_i[i]) begin
                acc = acc ^ a_i;
            end
        end
    end

    assign p_o = acc;
endmodule

// File: rtl/gf_mac_arbiter.sv
// rtl/gf_mac_arbiter.sv - shared GF(2^5) a*b^c unit with round-robin arbitration
module gf_mac_arbiter
    import gf32_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDW   = clog2(NREQ),
    parameter int SYM_W = GF_W
) (
    input  logic             clock,
    input  logic             reset,
    gf_mac_arbiter_if.slave  bus
);
    if (SYM_W != GF_W) begin : g_bad_sym_w
        $error("gf_mac_arbiter: SYM_W must be 5");
    end
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("gf_mac_arbiter: NREQ must be in 2..8");
    end

    logic            adv;
    logic            accept;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic [GF_W-1:0] prod;
    logic [GF_W-1:0] sum;

    logic            s1_v_q,  s1_v_d;
    logic [GF_W-1:0] s1_a_q,  s1_a_d;
    logic [GF_W-1:0] s1_b_q,  s1_b_d;
    logic [GF_W-1:0] s1_c_q,  s1_c_d;
    logic [IDW-1:0]  s1_id_q, s1_id_d;

    logic            res_valid_q, res_valid_d;
    logic [IDW-1:0]  res_id_q,    res_id_d;
    logic [GF_W-1:0] res_data_q,  res_data_d;

    // OUT moves whenever it is empty or drained; S1 refills whenever it moves on.
    assign adv    = !res_valid_q || bus.res_ready;
    assign accept = !s1_v_q || adv;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i     (clock),
        .rst_i     (reset),
        .req_i     (bus.req),
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_any_o (gnt_any)
    );

    lcpmult u_mul (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .p_o (prod)
    );

    gfadder u_add (
        .x_i (prod),
        .y_i (s1_c_q),
        .s_o (sum)
    );

    always_comb begin
        s1_v_d      = s1_v_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_c_d      = s1_c_q;
        s1_id_d     = s1_id_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_data_d  = res_data_q;

        if (accept) begin
            s1_v_d = gnt_any;
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) begin
                    s1_a_d = bus.op_a[i*GF_W +: GF_W];
                    s1_b_d = bus.op_b[i*GF_W +: GF_W];
                    s1_c_d = bus.op_c[i*GF_W +: GF_W];
                end
            end
            if (gnt_any) begin
                s1_id_d = gnt_idx;
            end
        end

        // An empty S1 drops valid but leaves the last id/data visible.
        if (adv) begin
            res_valid_d = s1_v_q;
            if (s1_v_q) begin
                res_id_d   = s1_id_q;
                res_data_d = sum;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_v_q      <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_c_q      <= '0;
            s1_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_c_q      <= s1_c_d;
            s1_id_q     <= s1_id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_data  = res_data_q;
endmodule
